// File: rtl/warp_pc_bank_pkg.sv
// Shared constants and helpers for the warp program-counter bank.
package warp_pc_bank_pkg;

    localparam int unsigned INSTMEM_ADDR_WIDTH = 16;

    // Select/index width for n items, never narrower than one bit
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Per-warp return-address LIFO; only the occupancy is reset, entries are don't-care.
module pc_ret_stack
    import warp_pc_bank_pkg::*;
#(
    parameter int unsigned ADDR_W      = INSTMEM_ADDR_WIDTH,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  logic                             pop,
    input  logic [ADDR_W-1:0]                din,
    output logic [ADDR_W-1:0]                top,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
    output logic                             full,
    output logic                             empty
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = sel_w(STACK_DEPTH);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];

    assign full  = (sp == SP_W'(STACK_DEPTH));
    assign empty = (sp == '0);
    assign top   = mem[IDX_W'(sp - SP_W'(1))];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[IDX_W'(sp)] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

endmodule

// File: rtl/warp_pc_bank.sv
// Multi-warp program-counter bank with per-warp call/return stacks and sticky error capture.
module warp_pc_bank
    import warp_pc_bank_pkg::*;
#(
    parameter int unsigned     ADDR_W      = INSTMEM_ADDR_WIDTH,
    parameter int unsigned     NUM_WARPS   = 4,
    parameter int unsigned     STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [sel_w(NUM_WARPS)-1:0]      warp_sel,
    input  logic                             incPC,
    input  logic                             loadFromI,
    input  logic                             call,
    input  logic                             ret,
    input  logic [ADDR_W-1:0]                I,
    output logic [ADDR_W-1:0]                AR,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
    output logic                             err_ovf,
    output logic                             err_unf,
    output logic [sel_w(NUM_WARPS)-1:0]      err_warp
);

    localparam int unsigned WS_W = sel_w(NUM_WARPS);
    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0]    pc      [NUM_WARPS];
    logic [ADDR_W-1:0]    stk_top [NUM_WARPS];
    logic [SP_W-1:0]      stk_sp  [NUM_WARPS];
    logic [NUM_WARPS-1:0] stk_full;
    logic [NUM_WARPS-1:0] stk_empty;
    logic [NUM_WARPS-1:0] push_v;
    logic [NUM_WARPS-1:0] pop_v;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_nxt;
    logic              do_push;
    logic              do_pop;
    logic              set_ovf;
    logic              set_unf;

    assign AR     = pc[warp_sel];
    assign sp     = stk_sp[warp_sel];
    assign pc_inc = AR + ADDR_W'(1);

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        assign push_v[w] = do_push && (warp_sel == WS_W'(w));
        assign pop_v[w]  = do_pop  && (warp_sel == WS_W'(w));

        pc_ret_stack #(
            .ADDR_W      (ADDR_W),
            .STACK_DEPTH (STACK_DEPTH)
        ) u_stack (
            .clk   (clk),
            .reset (reset),
            .push  (push_v[w]),
            .pop   (pop_v[w]),
            .din   (pc_inc),
            .top   (stk_top[w]),
            .sp    (stk_sp[w]),
            .full  (stk_full[w]),
            .empty (stk_empty[w])
        );
    end

    // Command decode: ret > call > loadFromI > incPC
    always_comb begin
        pc_nxt  = AR;
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (ret) begin
            if (stk_empty[warp_sel]) begin
                set_unf = 1'b1;
            end else begin
                do_pop = 1'b1;
                pc_nxt = stk_top[warp_sel];
            end
        end else if (call) begin
            if (stk_full[warp_sel]) begin
                set_ovf = 1'b1;
            end else begin
                do_push = 1'b1;
                pc_nxt  = I;
            end
        end else if (loadFromI) begin
            pc_nxt = I;
        end else if (incPC) begin
            pc_nxt = pc_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc[w] <= RESET_ADDR;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (warp_sel == WS_W'(w)) begin
                    pc[w] <= pc_nxt;
                end
            end
        end
    end

    // Sticky flags; err_warp latches only on the first error of either kind
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_ovf  <= 1'b0;
            err_unf  <= 1'b0;
            err_warp <= '0;
        end else begin
            if (set_ovf) begin
                err_ovf <= 1'b1;
            end
            if (set_unf) begin
                err_unf <= 1'b1;
            end
            if ((set_ovf || set_unf) && !(err_ovf || err_unf)) begin
                err_warp <= warp_sel;
            end
        end
    end

endmodule

// File: tb/tb_warp_pc_bank.sv
// Directed self-checking bench for warp_pc_bank with default parameters.
`timescale 1ns/1ps
module tb_warp_pc_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  warp_sel;
    logic        incPC;
    logic        loadFromI;
    logic        call;
    logic        ret;
    logic [15:0] I;
    logic [15:0] AR;
    logic [2:0]  sp;
    logic        err_ovf;
    logic        err_unf;
    logic [1:0]  err_warp;

    int vectors     = 0;
    int miscompares = 0;

    warp_pc_bank #(
        .ADDR_W      (16),
        .NUM_WARPS   (4),
        .STACK_DEPTH (4),
        .RESET_ADDR  (16'h0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .warp_sel  (warp_sel),
        .incPC     (incPC),
        .loadFromI (loadFromI),
        .call      (call),
        .ret       (ret),
        .I         (I),
        .AR        (AR),
        .sp        (sp),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf),
        .err_warp  (err_warp)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one command on the current warp_sel, sample 1 ns after the edge
    task automatic cmd(input logic r, input logic c, input logic l, input logic n,
                       input logic [15:0] tgt);
        ret = r; call = c; loadFromI = l; incPC = n; I = tgt;
        @(posedge clk);
        #1;
        ret = 1'b0; call = 1'b0; loadFromI = 1'b0; incPC = 1'b0;
    endtask

    // Short reset pulse placed between edges
    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; warp_sel = 2'd0; incPC = 1'b0; loadFromI = 1'b0;
        call = 1'b0; ret = 1'b0; I = 16'h0000;
        #2;
        chk("rst_ar", 32'(AR), 32'h0);
        chk("rst_sp", 32'(sp), 32'h0);
        chk("rst_err", {29'd0, err_ovf, err_unf, 1'b0} | 32'(err_warp), 32'h0);
        #19;
        reset = 1'b0;

        // Increment warp 0
        chk("inc0_ar", 32'(AR), 32'h0);
        cmd(0, 0, 0, 1, 16'h0); chk("inc1_ar", 32'(AR), 32'h1);
        cmd(0, 0, 0, 1, 16'h0); chk("inc2_ar", 32'(AR), 32'h2);
        cmd(0, 0, 0, 1, 16'h0); chk("inc3_ar", 32'(AR), 32'h3);
        for (int w = 1; w < 4; w++) begin
            warp_sel = 2'(w);
            #1;
            chk($sformatf("idle_w%0d_ar", w), 32'(AR), 32'h0);
        end

        // Jump priority and underflow on warp 2
        warp_sel = 2'd2;
        cmd(0, 0, 1, 1, 16'h0004); chk("ld_prio_ar", 32'(AR), 32'h4);
        cmd(1, 1, 0, 0, 16'h0099); chk("unf_ar", 32'(AR), 32'h4);
        chk("unf_sp", 32'(sp), 32'h0);
        chk("unf_flag", 32'(err_unf), 32'h1);
        chk("unf_ovf", 32'(err_ovf), 32'h0);
        chk("unf_warp", 32'(err_warp), 32'h2);

        // Call / return on warp 1
        warp_sel = 2'd1;
        cmd(0, 0, 1, 0, 16'h0010); chk("cr_ld_ar", 32'(AR), 32'h10);
        cmd(0, 1, 0, 0, 16'h0100); chk("cr_call_ar", 32'(AR), 32'h100);
        chk("cr_call_sp", 32'(sp), 32'h1);
        cmd(0, 0, 0, 1, 16'h0);
        cmd(0, 0, 0, 1, 16'h0);    chk("cr_inc_ar", 32'(AR), 32'h102);
        cmd(1, 0, 0, 0, 16'h0);    chk("cr_ret_ar", 32'(AR), 32'h11);
        chk("cr_ret_sp", 32'(sp), 32'h0);
        warp_sel = 2'd0; #1; chk("hold_w0", 32'(AR), 32'h3);
        warp_sel = 2'd2; #1; chk("hold_w2", 32'(AR), 32'h4);
        chk("hold_warp", 32'(err_warp), 32'h2);

        // Overflow on warp 3 from a clean reset
        pulse_reset();
        warp_sel = 2'd3;
        #1;
        chk("ovf_pre_ar", 32'(AR), 32'h0);
        chk("ovf_pre_unf", 32'(err_unf), 32'h0);
        cmd(0, 1, 0, 0, 16'h0020); chk("ovf_c1", {AR, 13'd0, sp}, {16'h0020, 16'h1});
        cmd(0, 1, 0, 0, 16'h0030); chk("ovf_c2", {AR, 13'd0, sp}, {16'h0030, 16'h2});
        cmd(0, 1, 0, 0, 16'h0040); chk("ovf_c3", {AR, 13'd0, sp}, {16'h0040, 16'h3});
        cmd(0, 1, 0, 0, 16'h0050); chk("ovf_c4", {AR, 13'd0, sp}, {16'h0050, 16'h4});
        chk("ovf_c4_flag", 32'(err_ovf), 32'h0);
        cmd(0, 1, 0, 0, 16'h0060); chk("ovf_c5", {AR, 13'd0, sp}, {16'h0050, 16'h4});
        chk("ovf_flag", 32'(err_ovf), 32'h1);
        chk("ovf_warp", 32'(err_warp), 32'h3);
        cmd(1, 0, 0, 0, 16'h0);    chk("ovf_r1", {AR, 13'd0, sp}, {16'h0041, 16'h3});
        cmd(1, 0, 0, 0, 16'h0);    chk("ovf_r2", {AR, 13'd0, sp}, {16'h0031, 16'h2});
        cmd(1, 0, 0, 0, 16'h0);    chk("ovf_r3", {AR, 13'd0, sp}, {16'h0021, 16'h1});
        cmd(1, 0, 0, 0, 16'h0);    chk("ovf_r4", {AR, 13'd0, sp}, {16'h0001, 16'h0});
        chk("ovf_no_unf", 32'(err_unf), 32'h0);

        // Address wrap on warp 0
        warp_sel = 2'd0;
        cmd(0, 0, 1, 0, 16'hFFFF); chk("wrap_ld", 32'(AR), 32'hFFFF);
        cmd(0, 0, 0, 1, 16'h0);    chk("wrap_inc", 32'(AR), 32'h0);
        cmd(0, 0, 1, 0, 16'hFFFF);
        cmd(0, 1, 0, 0, 16'h0200); chk("wrap_call", {AR, 13'd0, sp}, {16'h0200, 16'h1});
        cmd(1, 0, 0, 0, 16'h0);    chk("wrap_ret", {AR, 13'd0, sp}, {16'h0000, 16'h0});

        // Asynchronous reset with two entries pushed on warp 2
        warp_sel = 2'd2;
        cmd(0, 1, 0, 0, 16'h0300);
        cmd(0, 1, 0, 0, 16'h0400); chk("ar_pre", {AR, 13'd0, sp}, {16'h0400, 16'h2});
        reset = 1'b1;
        #1;
        chk("ar_ar", 32'(AR), 32'h0);
        chk("ar_sp", 32'(sp), 32'h0);
        chk("ar_flags", {30'd0, err_ovf, err_unf}, 32'h0);
        chk("ar_warp", 32'(err_warp), 32'h0);
        #2;
        reset = 1'b0;
        cmd(1, 0, 0, 0, 16'h0);
        chk("ar_ret_unf", 32'(err_unf), 32'h1);
        chk("ar_ret_warp", 32'(err_warp), 32'h2);
        chk("ar_ret_ar", 32'(AR), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/warp_pc_bank.md
# warp_pc_bank

Parametrised program-counter bank for the tinyGPU scheduler. Holds one program counter per warp plus a per-warp return-address stack, so the scheduler can step, jump, call and return on any warp by selecting it with `warp_sel`. Drives the instruction-memory address `AR` for the selected warp. It is the multi-warp, subroutine-capable successor of the single-warp `pc` block.

## Interface
Parameters:
- `ADDR_W`, 16: PC / instruction-memory address width (`INSTMEM_ADDR_WIDTH`).
- `NUM_WARPS`, 4: number of independent PCs, ≥1.
- `STACK_DEPTH`, 4: return-stack entries per warp, ≥1.
- `RESET_ADDR`, 0: value loaded into every PC on reset.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `warp_sel`, in, `max(1,$clog2(NUM_WARPS))`: warp addressed by this cycle's command and by `AR`.
- `incPC`, in, 1: PC[warp_sel] ← PC+1.
- `loadFromI`, in, 1: PC[warp_sel] ← `I` (jump).
- `call`, in, 1: push PC+1, then PC ← `I`.
- `ret`, in, 1: pop the stack top into PC.
- `I`, in, `ADDR_W`: jump/call target.
- `AR`, out, `ADDR_W`: PC[warp_sel], combinational read of the register.
- `sp`, out, `$clog2(STACK_DEPTH+1)`: stack occupancy of warp_sel.
- `err_ovf`, out, 1: sticky; a call hit a full stack.
- `err_unf`, out, 1: sticky; a ret hit an empty stack.
- `err_warp`, out, `warp_sel` width: warp of the first error.

## Operation
- Reset sets every PC to `RESET_ADDR` and every sp to 0. It also clears `err_ovf`, `err_unf` and `err_warp` to 0. Stack contents are don't-care after reset.
- One command per cycle, applied only to `warp_sel`. All other warps hold.
- If several strobes are high at once, priority is `ret` > `call` > `loadFromI` > `incPC`. Lower-priority strobes are ignored.
- No strobe high: the PC holds.
- Arithmetic is modulo 2^ADDR_W. PC+1 from all-ones wraps to 0. The pushed return address wraps the same way.
- `call` with sp < STACK_DEPTH: write stack[sp] ← PC+1, sp ← sp+1, PC ← `I`.
- `call` with sp == STACK_DEPTH: no push, PC unchanged, sp unchanged, `err_ovf` ← 1.
- `ret` with sp > 0: PC ← stack[sp-1], sp ← sp-1.
- `ret` with sp == 0: PC unchanged, `err_unf` ← 1.
- `err_warp` captures `warp_sel` only on the first error of either kind since reset. It does not change on later errors.
- Error flags clear only on reset.

## Timing
- Commands are sampled at the rising edge. The new PC and sp are visible on `AR` and `sp` immediately after that edge, so a command has 1-cycle latency.
- `AR` and `sp` follow `warp_sel` combinationally, with 0-cycle latency from a `warp_sel` change.
- Back-to-back commands on the same warp are legal every cycle. `call` then `ret` on consecutive cycles returns to the pushed address.
- Reset is asserted asynchronously. Outputs reach reset values without a clock edge. Deassertion is assumed synchronous to `clk` upstream.
- Reset during a call or return sequence discards all stack state.

## Structure
- Shared constants: `INSTMEM_ADDR_WIDTH` lives in the shared constants include, which is the default source for `ADDR_W`. No new typedefs are needed.
- Sub-module `pc_ret_stack`: per-warp LIFO with parameters `ADDR_W` and `STACK_DEPTH`.
  - Inputs: push, pop, din.
  - Outputs: top, sp, full, empty.
  - Async reset clears sp.
- `warp_pc_bank` instantiates `NUM_WARPS` copies of `pc_ret_stack` in a generate loop. It also holds the PC register array, priority decode, mux and error logic.

## Test plan
- Reset then increment: reset for 21 ns, then `incPC`=1 on warp 0 for 3 edges → `AR`=0,1,2,3. Warps 1–3 read 0.
- Jump and priority: warp 2, `I`=0x0004, `loadFromI`=`incPC`=1 → `AR`=0x0004, since load wins. Then `ret`=`call`=1 with sp=0 → PC stays 0x0004, `err_unf`=1, `err_warp`=2.
- Call/return: warp 1 at PC 0x0010, `call` with `I`=0x0100 → `AR`=0x0100, `sp`=1. `incPC`×2 → 0x0102. `ret` → `AR`=0x0011, `sp`=0.
- Overflow: `STACK_DEPTH`=4, 5 calls on warp 3 → `sp`=4. The 5th call leaves PC at the 4th target, sets `err_ovf`=1 and `err_warp`=3. Four rets unwind in LIFO order.
- Wrap: `loadFromI` 0xFFFF then `incPC` → `AR`=0x0000. A call at 0xFFFF pushes 0x0000, and `ret` returns 0x0000.
- Async reset mid-operation: assert `reset` between edges with sp=2 → `AR`=`RESET_ADDR`, `sp`=0 and all error flags 0 before the next edge. A following `ret` → `err_unf`=1.
